// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding select codes and MDU scoreboard state encoding
package fwd_pkg;
    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} mdu_state_t;
endpackage

// File: rtl/fwd_hazard_unit_mdu_scoreboard.sv
// mdu_scoreboard: multi-cycle MDU busy counter with registered busy/done outputs
module mdu_scoreboard
    import fwd_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done
);
    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);
    mdu_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic r_busy;
    logic r_done;
    // a start (re)loads the full latency; done is raised for the cycle where the count is 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_start) begin
            r_state <= BUSY;
            r_cnt   <= CW'(MDU_LAT);
            r_busy  <= 1'b1;
            r_done  <= (MDU_LAT == 1);
        end else if (r_state == BUSY) begin
            r_cnt   <= r_cnt - ONE;
            r_state <= (r_cnt == ONE) ? RUN : BUSY;
            r_busy  <= (r_cnt != ONE);
            r_done  <= (r_cnt == TWO);
        end
    end
    // the ID-stage stall must prevent a second MDU op while one is in flight
    assert property (@(posedge clk) disable iff (rst) !(i_start && r_state == BUSY));
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use and MDU stall control (optional stats: FWD_HAZARD_STATS_EN)
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MDU_LAT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_use,
    input  logic                      id_hilo_use,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
    input  logic [NUM_SRC-1:0]        ex_src_use,
    input  logic                      id_ex_memread,
    input  logic [REG_AW-1:0]         id_ex_dst,
    input  logic                      mdu_start,
    input  logic                      ex_mem_regwrite,
    input  logic [REG_AW-1:0]         ex_mem_dst,
    input  logic                      mem_wb_regwrite,
    input  logic [REG_AW-1:0]         mem_wb_dst,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall_pc,
    output logic                      stall_ifid,
    output logic                      bubble_idex,
    output logic                      mdu_busy,
    output logic                      mdu_done
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]               stat_stall_cycles,
    output logic [31:0]               stat_fwd_events
`endif
);
    logic [2*NUM_SRC-1:0] w_fwd;
    logic [NUM_SRC-1:0]   w_ex_hit;
    logic [NUM_SRC-1:0]   w_wb_hit;
    logic [NUM_SRC-1:0]   w_lu_hit;
    logic                 w_lu;
    logic                 w_ms;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_ex_hit[g] = ex_src_use[g] && ex_mem_regwrite && ex_mem_dst != '0
                             && ex_mem_dst == ex_src_addr[g*REG_AW +: REG_AW];
        assign w_wb_hit[g] = ex_src_use[g] && mem_wb_regwrite && mem_wb_dst != '0
                             && mem_wb_dst == ex_src_addr[g*REG_AW +: REG_AW];
        assign w_fwd[2*g +: 2] = w_ex_hit[g] ? FWD_EX_MEM : w_wb_hit[g] ? FWD_MEM_WB : FWD_RF;
        assign w_lu_hit[g] = id_src_use[g] && id_src_addr[g*REG_AW +: REG_AW] == id_ex_dst;
    end

    mdu_scoreboard #(.MDU_LAT(MDU_LAT)) u_mdu (
        .clk     (clk),
        .rst     (rst),
        .i_start (mdu_start),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    assign w_lu    = id_ex_memread && id_ex_dst != '0 && |w_lu_hit;
    assign w_ms    = id_hilo_use && (w_busy || mdu_start);
    assign w_stall = !rst && (w_lu || w_ms);

    assign fwd_sel     = rst ? '0 : w_fwd;
    assign stall_pc    = w_stall;
    assign stall_ifid  = w_stall;
    assign bubble_idex = w_stall;
    assign mdu_busy    = !rst && w_busy;
    assign mdu_done    = !rst && w_done;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_fwd_events;
    // saturating event counters for stall cycles and forwarded cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_fwd_events   <= '0;
        end else begin
            if (w_stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (|w_fwd && r_fwd_events != '1) r_fwd_events <= r_fwd_events + 32'd1;
        end
    end
    assign stat_stall_cycles = r_stall_cycles;
    assign stat_fwd_events   = r_fwd_events;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding, load-use, MDU stall and reset behaviour
module tb_fwd_hazard_unit;
    localparam int AW  = 5;
    localparam int NS  = 3;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NS*AW-1:0] id_src_addr = '0;
    logic [NS*AW-1:0] ex_src_addr = '0;
    logic [NS-1:0]    id_src_use  = '0;
    logic [NS-1:0]    ex_src_use  = '0;
    logic id_hilo_use = 1'b0, id_ex_memread = 1'b0, mdu_start = 1'b0;
    logic ex_mem_regwrite = 1'b0, mem_wb_regwrite = 1'b0;
    logic [AW-1:0] id_ex_dst = '0, ex_mem_dst = '0, mem_wb_dst = '0;
    logic [2*NS-1:0] fwd_sel;
    logic stall_pc, stall_ifid, bubble_idex, mdu_busy, mdu_done;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stall_cycles, stat_fwd_events;
`endif
    int checks = 0;
    int errors = 0;
    int e_stall = 0;
    int e_fwd = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .MDU_LAT(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_src_addr     (id_src_addr),
        .id_src_use      (id_src_use),
        .id_hilo_use     (id_hilo_use),
        .ex_src_addr     (ex_src_addr),
        .ex_src_use      (ex_src_use),
        .id_ex_memread   (id_ex_memread),
        .id_ex_dst       (id_ex_dst),
        .mdu_start       (mdu_start),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_dst      (ex_mem_dst),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_dst      (mem_wb_dst),
        .fwd_sel         (fwd_sel),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .bubble_idex     (bubble_idex),
        .mdu_busy        (mdu_busy),
        .mdu_done        (mdu_done)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_fwd_events   (stat_fwd_events)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one cycle: checks outputs after inputs settle, then accounts this cycle into the stat model
    task automatic step(input string tag, input logic [5:0] f, input logic s, input logic b, input logic d);
        #1;
`ifdef FWD_HAZARD_STATS_EN
        chk({tag, "/stat_stall"}, stat_stall_cycles, e_stall);
        chk({tag, "/stat_fwd"}, stat_fwd_events, e_fwd);
`endif
        chk({tag, "/fwd_sel"}, {26'b0, fwd_sel}, {26'b0, f});
        chk({tag, "/stall_pc"}, {31'b0, stall_pc}, {31'b0, s});
        chk({tag, "/stall_ifid"}, {31'b0, stall_ifid}, {31'b0, s});
        chk({tag, "/bubble_idex"}, {31'b0, bubble_idex}, {31'b0, s});
        chk({tag, "/mdu_busy"}, {31'b0, mdu_busy}, {31'b0, b});
        chk({tag, "/mdu_done"}, {31'b0, mdu_done}, {31'b0, d});
        if (rst) begin
            e_stall = 0;
            e_fwd = 0;
        end else begin
            e_stall += int'(s);
            e_fwd += int'(f != 6'b0);
        end
    endtask

    initial begin
        ex_mem_regwrite = 1'b1; ex_mem_dst = 5'd3;
        ex_src_addr = {5'd0, 5'd0, 5'd3}; ex_src_use = 3'b001;
        id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        id_src_addr = {5'd0, 5'd0, 5'd8}; id_src_use = 3'b001; id_hilo_use = 1'b1;
        @(negedge clk); step("reset", 6'b0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; ex_mem_regwrite = 1'b0; id_ex_memread = 1'b0; id_hilo_use = 1'b0;
        step("idle", 6'b0, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b1; step("ex_mem", 6'b000010, 0, 0, 0);
        @(negedge clk); mem_wb_regwrite = 1'b1; mem_wb_dst = 5'd3; step("ex_over_wb", 6'b000010, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b0; step("mem_wb", 6'b000001, 0, 0, 0);
        @(negedge clk); mem_wb_regwrite = 1'b0; ex_mem_regwrite = 1'b1; ex_mem_dst = 5'd0; ex_src_addr = '0;
        step("ex_r0", 6'b0, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b1; mem_wb_dst = 5'd0;
        step("wb_r0", 6'b0, 0, 0, 0);
        @(negedge clk); mem_wb_regwrite = 1'b0; ex_mem_regwrite = 1'b1; ex_mem_dst = 5'd5;
        ex_src_addr = {5'd0, 5'd5, 5'd0}; ex_src_use = 3'b000;
        step("imm_op1", 6'b0, 0, 0, 0);
        @(negedge clk); ex_src_use = 3'b010; step("op1_ex", 6'b001000, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b1; mem_wb_dst = 5'd9;
        ex_src_addr = {5'd9, 5'd0, 5'd0}; ex_src_use = 3'b100;
        step("op2_wb", 6'b010000, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b1; ex_mem_dst = 5'd7;
        ex_src_addr = {5'd7, 5'd9, 5'd7}; ex_src_use = 3'b111;
        step("mixed", 6'b100110, 0, 0, 0);
        @(negedge clk); ex_mem_dst = 5'd6; step("ex_nomatch", 6'b000100, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0; ex_src_use = '0; ex_src_addr = '0;
        step("fwd_clear", 6'b0, 0, 0, 0);

        @(negedge clk); id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        id_src_addr = {5'd0, 5'd0, 5'd8}; id_src_use = 3'b001;
        step("lu", 6'b0, 1, 0, 0);
        @(negedge clk); id_ex_memread = 1'b0; step("lu_after", 6'b0, 0, 0, 0);
        @(negedge clk); id_ex_memread = 1'b1; id_src_use = 3'b000; step("lu_nouse", 6'b0, 0, 0, 0);
        @(negedge clk); id_src_addr = {5'd8, 5'd0, 5'd0}; id_src_use = 3'b100; step("lu_op2", 6'b0, 1, 0, 0);
        @(negedge clk); id_ex_dst = 5'd9; step("lu_diff", 6'b0, 0, 0, 0);
        @(negedge clk); id_ex_dst = 5'd0; id_src_addr = '0; id_src_use = 3'b111; step("lu_r0", 6'b0, 0, 0, 0);
        @(negedge clk); id_ex_memread = 1'b0; id_ex_dst = 5'd8; id_src_addr = {5'd0, 5'd0, 5'd8};
        id_src_use = 3'b001; step("lu_noload", 6'b0, 0, 0, 0);

        @(negedge clk); id_src_use = '0; mdu_start = 1'b1; id_hilo_use = 1'b1; step("mdu_t", 6'b0, 1, 0, 0);
        @(negedge clk); mdu_start = 1'b0; step("mdu_1", 6'b0, 1, 1, 0);
        @(negedge clk); id_hilo_use = 1'b0; step("mdu_2_nohilo", 6'b0, 0, 1, 0);
        @(negedge clk); id_hilo_use = 1'b1; step("mdu_3", 6'b0, 1, 1, 0);
        @(negedge clk); step("mdu_4", 6'b0, 1, 1, 1);
        @(negedge clk); step("mdu_5", 6'b0, 0, 0, 0);

        @(negedge clk); id_hilo_use = 1'b0; mdu_start = 1'b1; step("nh_t", 6'b0, 0, 0, 0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk); mdu_start = 1'b0; step("nh_busy", 6'b0, 0, 1, k == LAT);
        end
        @(negedge clk); step("nh_end", 6'b0, 0, 0, 0);

        @(negedge clk); mdu_start = 1'b1; id_hilo_use = 1'b1; step("rb_t", 6'b0, 1, 0, 0);
        @(negedge clk); mdu_start = 1'b0; step("rb_1", 6'b0, 1, 1, 0);
        @(negedge clk); rst = 1'b1; ex_mem_regwrite = 1'b1; ex_mem_dst = 5'd4;
        ex_src_addr = {5'd0, 5'd0, 5'd4}; ex_src_use = 3'b001;
        step("rb_rst", 6'b0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; step("rb_2", 6'b000010, 0, 0, 0);
        @(negedge clk); ex_mem_regwrite = 1'b0; step("rb_3", 6'b0, 0, 0, 0);
        @(negedge clk); step("rb_4", 6'b0, 0, 0, 0);
        @(negedge clk); step("rb_5", 6'b0, 0, 0, 0);

        @(negedge clk); mdu_start = 1'b1; id_ex_memread = 1'b1; id_ex_dst = 5'd8;
        id_src_addr = {5'd0, 5'd0, 5'd8}; id_src_use = 3'b001;
        step("combo", 6'b0, 1, 0, 0);
        @(negedge clk); mdu_start = 1'b0; id_ex_memread = 1'b0; step("combo_1", 6'b0, 1, 1, 0);
        @(negedge clk); step("combo_2", 6'b0, 1, 1, 0);
        @(negedge clk); step("combo_3", 6'b0, 1, 1, 0);
        @(negedge clk); step("combo_4", 6'b0, 1, 1, 1);
        @(negedge clk); id_hilo_use = 1'b0; step("combo_5", 6'b0, 0, 0, 0);
        @(negedge clk); step("final", 6'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
